f2c_multichan_dma: RTL and testbench

//  FPGA->CPU DMA engine, multi-channel successor to the single-ring F2C logic.

---
 rtl/f2c_multichan_dma.sv | 164 ++++++++++++++++
 tb/tb_f2c_multichan_dma.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2c_multichan_dma.sv
// Multi-channel FPGA->CPU DMA engine: streams per-channel QWs into host ring chunks,
// then posts the channel's new write pointer to the metrics region on the same TLP stream.
module f2c_multichan_dma #(
  parameter int NUM_CHAN     = 2,
  parameter int CHUNK_LOG2   = 4,
  parameter int QW_PER_CHUNK = 16,
  parameter int ADDR_W       = 30
) (
  input  logic                           pcieClk_in,
  input  logic                           reset_in,
  input  logic                           enable_in,
  input  logic [ADDR_W-1:0]              mtrBase_in,
  input  logic [NUM_CHAN*ADDR_W-1:0]     f2cBase_in,
  input  logic [NUM_CHAN-1:0]            rdPtrWr_in,
  input  logic [CHUNK_LOG2-1:0]          rdPtrVal_in,
  input  logic [NUM_CHAN*64-1:0]         srcData_in,
  input  logic [NUM_CHAN-1:0]            srcValid_in,
  output logic [NUM_CHAN-1:0]            srcReady_out,
  output logic                           txValid_out,
  input  logic                           txReady_in,
  output logic                           txSop_out,
  output logic                           txEop_out,
  output logic [ADDR_W-1:0]              txAddr_out,
  output logic [9:0]                     txDwLen_out,
  output logic [63:0]                    txData_out,
  output logic [NUM_CHAN-1:0]            chanFull_out,
  output logic [1:0]                     dbgState_out,
  output logic [NUM_CHAN*CHUNK_LOG2-1:0] dbgWrPtr_out
);

  localparam int CH_W        = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int BEAT_W      = (QW_PER_CHUNK > 1) ? $clog2(QW_PER_CHUNK) : 1;
  localparam int CHUNK_SHIFT = $clog2(2 * QW_PER_CHUNK);
  localparam logic [9:0]            DATA_DW   = 10'(2 * QW_PER_CHUNK);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(QW_PER_CHUNK - 1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
  localparam logic [CHUNK_LOG2-1:0] PTR_ONE   = CHUNK_LOG2'(1);
  localparam logic [CH_W-1:0]       CH_ONE    = CH_W'(1);
  localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_CHAN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PTR  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, arb_q, grant_ch;
  logic                  grant_found;
  logic [BEAT_W-1:0]     beat_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CHUNK_LOG2-1:0] wr_ptr_q [NUM_CHAN];
  logic [CHUNK_LOG2-1:0] rd_ptr_q [NUM_CHAN];
  logic [NUM_CHAN-1:0]   full_q, elig;
  logic [ADDR_W-1:0]     base_arr [NUM_CHAN];
  logic [63:0]           data_arr [NUM_CHAN];
  logic                  beat_fire, last_fire;

  always_comb begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      base_arr[c] = f2cBase_in[c*ADDR_W +: ADDR_W];
      data_arr[c] = srcData_in[c*64 +: 64];
      dbgWrPtr_out[c*CHUNK_LOG2 +: CHUNK_LOG2] = wr_ptr_q[c];
    end
  end

  assign elig         = {NUM_CHAN{enable_in}} & ~full_q & srcValid_in;
  assign chanFull_out = full_q;
  assign dbgState_out = state_q;

  // Round-robin: arb_q holds the highest-priority channel, i.e. the one after the last grant.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = 0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      cand = (int'(arb_q) + i) % NUM_CHAN;
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(cand);
      end
    end
  end

  assign beat_fire = (state_q == ST_DATA) && srcValid_in[ch_q] && txReady_in;
  assign last_fire = beat_fire && (beat_q == LAST_BEAT);

  // Handshake: a beat moves on any cycle where txValid_out && txReady_in. In DATA the source is
  // passed straight through (txValid = srcValid, srcReady = txReady), so a source bubble only
  // stalls the TLP; in PTR txValid is held high until the single beat is accepted.
  always_comb begin
    state_d      = state_q;
    srcReady_out = '0;
    txValid_out  = 1'b0;
    txSop_out    = 1'b0;
    txEop_out    = 1'b0;
    txAddr_out   = '0;
    txDwLen_out  = '0;
    txData_out   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) state_d = ST_DATA;
      end
      ST_DATA: begin
        srcReady_out[ch_q] = txReady_in;
        txValid_out        = srcValid_in[ch_q];
        txSop_out          = srcValid_in[ch_q] && (beat_q == '0);
        txEop_out          = srcValid_in[ch_q] && (beat_q == LAST_BEAT);
        txAddr_out         = addr_q;
        txDwLen_out        = DATA_DW;
        txData_out         = data_arr[ch_q];
        if (last_fire) state_d = ST_PTR;
      end
      ST_PTR: begin
        txValid_out = 1'b1;
        txSop_out   = 1'b1;
        txEop_out   = 1'b1;
        txAddr_out  = addr_q;
        txDwLen_out = 10'd1;
        txData_out  = {32'b0, 32'(wr_ptr_q[ch_q])};
        if (txReady_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      arb_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      full_q  <= '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      // Base addresses are captured at SOP so host reprogramming never splits a TLP.
      if (state_q == ST_IDLE && grant_found) begin
        ch_q   <= grant_ch;
        arb_q  <= (grant_ch == CH_LAST) ? '0 : grant_ch + CH_ONE;
        addr_q <= base_arr[grant_ch] + (ADDR_W'(wr_ptr_q[grant_ch]) << CHUNK_SHIFT);
        beat_q <= '0;
      end
      if (beat_fire) beat_q <= last_fire ? '0 : beat_q + BEAT_ONE;
      if (last_fire) addr_q <= mtrBase_in + ADDR_W'(ch_q);
      for (int c = 0; c < NUM_CHAN; c++) begin
        full_q[c] <= (wr_ptr_q[c] + PTR_ONE) == rd_ptr_q[c];
        if (state_q == ST_IDLE && !enable_in) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
        end else begin
          if (enable_in && rdPtrWr_in[c]) rd_ptr_q[c] <= rdPtrVal_in;
          if (last_fire && int'(ch_q) == c) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_f2c_multichan_dma.sv
// Directed bench for f2c_multichan_dma: captures every accepted TLP beat and compares it
// against beats built from an independent ring/pointer model.
module tb_f2c_multichan_dma;

  localparam int NC = 2;
  localparam int CL = 4;
  localparam int QW = 16;
  localparam int AW = 30;

  typedef logic [105:0] beat_t;

  logic                clk = 1'b0;
  logic                reset_in;
  logic                enable;
  logic [AW-1:0]       mtr_base;
  logic [NC*AW-1:0]    f2c_base;
  logic [NC-1:0]       rd_ptr_wr;
  logic [CL-1:0]       rd_ptr_val;
  logic [NC*64-1:0]    src_data;
  logic [NC-1:0]       src_valid;
  logic [NC-1:0]       src_ready;
  logic                tx_valid, tx_ready, tx_sop, tx_eop;
  logic [AW-1:0]       tx_addr;
  logic [9:0]          tx_dw_len;
  logic [63:0]         tx_data;
  logic [NC-1:0]       chan_full;
  logic [1:0]          dbg_state;
  logic [NC*CL-1:0]    dbg_wr_ptr;

  int    n_checks = 0;
  int    n_errs   = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    src_seq[NC];
  int    src_lim[NC];
  logic  src_en[NC];
  int    valid_pct, ready_pct;
  int    seq0;

  f2c_multichan_dma #(.NUM_CHAN(NC), .CHUNK_LOG2(CL), .QW_PER_CHUNK(QW), .ADDR_W(AW)) dut (
    .pcieClk_in(clk), .reset_in(reset_in), .enable_in(enable),
    .mtrBase_in(mtr_base), .f2cBase_in(f2c_base),
    .rdPtrWr_in(rd_ptr_wr), .rdPtrVal_in(rd_ptr_val),
    .srcData_in(src_data), .srcValid_in(src_valid), .srcReady_out(src_ready),
    .txValid_out(tx_valid), .txReady_in(tx_ready), .txSop_out(tx_sop), .txEop_out(tx_eop),
    .txAddr_out(tx_addr), .txDwLen_out(tx_dw_len), .txData_out(tx_data),
    .chanFull_out(chan_full), .dbgState_out(dbg_state), .dbgWrPtr_out(dbg_wr_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] seq_word(int c, int i);
    return {8'hA5, 8'(c), 16'h0000, 32'(i)};
  endfunction

  // Address/length only matter on SOP beats, so they are zeroed elsewhere.
  function automatic beat_t make_beat(logic sop, logic eop, logic [AW-1:0] addr,
                                      logic [9:0] len, logic [63:0] data);
    return {sop, eop, sop ? addr : {AW{1'b0}}, sop ? len : 10'd0, data};
  endfunction

  function automatic void push_chunk(int c, int wr, int first);
    logic [AW-1:0] a;
    a = f2c_base[c*AW +: AW] + AW'(wr * 2 * QW);
    for (int j = 0; j < QW; j++)
      exp_q.push_back(make_beat(j == 0, j == QW - 1, a, 10'(2 * QW), seq_word(c, first + j)));
    exp_q.push_back(make_beat(1'b1, 1'b1, mtr_base + AW'(c), 10'd1, 64'((wr + 1) % (1 << CL))));
  endfunction

  task automatic run_cycle();
    for (int c = 0; c < NC; c++) begin
      src_data[c*64 +: 64] = seq_word(c, src_seq[c]);
      src_valid[c] = src_en[c] && (src_seq[c] < src_lim[c]) && ($urandom_range(99) < valid_pct);
    end
    tx_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (tx_valid === 1'b1 && tx_ready)
      got_q.push_back(make_beat(tx_sop, tx_eop, tx_addr, tx_dw_len, tx_data));
    for (int c = 0; c < NC; c++)
      if (src_valid[c] && src_ready[c] === 1'b1) src_seq[c]++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_in  = 1'b1;
    enable    = 1'b1;
    src_valid = '0;
    tx_ready  = 1'b0;
    rd_ptr_wr = '0;
    rd_ptr_val = '0;
    valid_pct = 100;
    ready_pct = 100;
    for (int c = 0; c < NC; c++) begin
      src_seq[c] = 0;
      src_lim[c] = 0;
      src_en[c]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_in = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    mtr_base = 30'h400;
    f2c_base = {30'h2000, 30'h1000};
    src_data = '0;
    apply_reset();
    #1;
    n_checks++;
    if ({tx_valid, tx_sop, tx_eop} !== 3'b000) begin
      n_errs++; $display("FAIL reset_tx got=%b exp=000", {tx_valid, tx_sop, tx_eop});
    end
    n_checks++;
    if (src_ready !== 2'b00) begin n_errs++; $display("FAIL reset_src_ready got=%b exp=00", src_ready); end
    n_checks++;
    if (chan_full !== 2'b00) begin n_errs++; $display("FAIL reset_full got=%b exp=00", chan_full); end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_errs++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_checks++;
    if (dbg_wr_ptr !== '0) begin n_errs++; $display("FAIL reset_wr_ptr got=%h exp=0", dbg_wr_ptr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_channel();
    f2c_base = {30'h2000, 30'h0};
    mtr_base = 30'h400;
    apply_reset();
    src_en[0] = 1'b1;
    src_lim[0] = 16;
    for (int k = 0; k < 40; k++) run_cycle();
    push_chunk(0, 0, 0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL single_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_ring_full();
    f2c_base = {30'h2000, 30'h100000};
    mtr_base = 30'h400;
    apply_reset();
    src_en[0] = 1'b1;
    src_lim[0] = 100000;
    for (int k = 0; k < 400; k++) run_cycle();
    for (int n = 0; n < 15; n++) push_chunk(0, n, n * QW);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL full_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
    n_checks++;
    if (chan_full[0] !== 1'b1 || src_ready[0] !== 1'b0) begin
      n_errs++; $display("FAIL full_flag got full=%b ready=%b exp full=1 ready=0", chan_full[0], src_ready[0]);
    end
    exp_q.delete();
    got_q.delete();
    rd_ptr_val = 4'd1;
    rd_ptr_wr  = 2'b01;
    run_cycle();
    rd_ptr_wr = 2'b00;
    for (int k = 0; k < 40; k++) run_cycle();
    push_chunk(0, 15, 15 * QW);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL wrap_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
    n_checks++;
    if (chan_full[0] !== 1'b1 || dbg_wr_ptr[CL-1:0] !== 4'd0) begin
      n_errs++; $display("FAIL wrap_ptr got full=%b wr=%0d exp full=1 wr=0", chan_full[0], dbg_wr_ptr[CL-1:0]);
    end
  endtask

  task automatic test_round_robin();
    f2c_base = {30'h2000, 30'h1000};
    mtr_base = 30'h400;
    apply_reset();
    src_en[0] = 1'b1;
    src_en[1] = 1'b1;
    src_lim[0] = 32;
    src_lim[1] = 32;
    for (int k = 0; k < 200; k++) run_cycle();
    push_chunk(0, 0, 0);
    push_chunk(1, 0, 0);
    push_chunk(0, 1, 16);
    push_chunk(1, 1, 16);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL rr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL rr_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    f2c_base = {30'h2000, 30'h3000};
    mtr_base = 30'h800;
    apply_reset();
    src_en[0] = 1'b1;
    src_lim[0] = 48;
    valid_pct = 70;
    ready_pct = 60;
    for (int k = 0; k < 1500 && got_q.size() < 51; k++) run_cycle();
    for (int k = 0; k < 10; k++) run_cycle();
    for (int n = 0; n < 3; n++) push_chunk(0, n, n * QW);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL bp_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
    n_checks++;
    if (src_seq[0] !== 48) begin n_errs++; $display("FAIL bp_consumed got=%0d exp=48", src_seq[0]); end
  endtask

  task automatic test_disable();
    f2c_base = {30'h2000, 30'h5000};
    mtr_base = 30'h400;
    apply_reset();
    src_en[0] = 1'b1;
    src_lim[0] = 100000;
    for (int k = 0; k < 100 && got_q.size() < 25; k++) run_cycle();
    enable = 1'b0;
    for (int k = 0; k < 30; k++) run_cycle();
    push_chunk(0, 0, 0);
    push_chunk(0, 1, 16);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL dis_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL dis_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
    n_checks++;
    if (dbg_wr_ptr !== '0) begin n_errs++; $display("FAIL dis_wr_ptr got=%h exp=0", dbg_wr_ptr); end
    rd_ptr_val = 4'd1;
    rd_ptr_wr  = 2'b01;
    run_cycle();
    rd_ptr_wr = 2'b00;
    run_cycle();
    run_cycle();
    n_checks++;
    if (chan_full !== 2'b00) begin n_errs++; $display("FAIL dis_rdptr_ignored got=%b exp=00", chan_full); end
    exp_q.delete();
    got_q.delete();
    enable = 1'b1;
    for (int k = 0; k < 60 && got_q.size() < 17; k++) run_cycle();
    push_chunk(0, 0, 32);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL reen_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL reen_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_tlp();
    f2c_base = {30'h2000, 30'h7000};
    mtr_base = 30'h400;
    apply_reset();
    src_en[0] = 1'b1;
    src_lim[0] = 100000;
    for (int k = 0; k < 50 && got_q.size() < 5; k++) run_cycle();
    reset_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({tx_valid, tx_sop, tx_eop} !== 3'b000 || src_ready !== 2'b00) begin
      n_errs++; $display("FAIL midrst_out got=%b/%b exp=000/00", {tx_valid, tx_sop, tx_eop}, src_ready);
    end
    n_checks++;
    if (dbg_wr_ptr !== '0 || dbg_state !== 2'd0 || chan_full !== 2'b00) begin
      n_errs++; $display("FAIL midrst_state got wr=%h st=%0d full=%b exp 0/0/00", dbg_wr_ptr, dbg_state, chan_full);
    end
    reset_in = 1'b0;
    exp_q.delete();
    got_q.delete();
    seq0 = src_seq[0];
    for (int k = 0; k < 60 && got_q.size() < 17; k++) run_cycle();
    push_chunk(0, 0, seq0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errs++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL midrst_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : beat_t'(0), exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_ring_full();
    test_round_robin();
    test_backpressure();
    test_disable();
    test_reset_mid_tlp();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
